// File: rtl/udp_stream_pkg.sv
// udp_stream_pkg: shared constants and types for the UDP stream packetizer.
//   - UDP core result codes seen on udp_out_result
//   - bank fill state and drain FSM state encodings
//   - payload byte width used by the bank RAM
package udp_stream_pkg;

  localparam int unsigned DATA_BITS = 8;

  localparam logic [1:0] UDP_RES_IDLE    = 2'b00;
  localparam logic [1:0] UDP_RES_SENDING = 2'b01;
  localparam logic [1:0] UDP_RES_ERR     = 2'b10;
  localparam logic [1:0] UDP_RES_SENT    = 2'b11;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_t;

  typedef enum logic [2:0] {
    DR_IDLE = 3'd0,
    DR_REQ  = 3'd1,
    DR_SEND = 3'd2,
    DR_WAIT = 3'd3,
    DR_DONE = 3'd4
  } drain_state_t;

endpackage

// File: rtl/udp_stream_bank_ram.sv
// udp_stream_bank_ram: simple dual-port payload RAM holding both ping-pong banks.
// Ports:
//   clk                       - clock
//   wr_en, wr_addr, wr_data   - write port ({bank, ptr} address)
//   rd_en, rd_addr            - read request ({bank, ptr} address)
//   rd_data                   - registered read data, valid the clock after rd_en
module udp_stream_bank_ram
  import udp_stream_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 11
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;

  logic [DATA_BITS-1:0] mem [DEPTH];

  // Write port and registered read port; rd_data holds when rd_en is low.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/udp_stream_packetizer.sv
// udp_stream_packetizer: store-and-forward AXI-Stream to UDP port-slot packetizer.
// Payload bytes fill one of two ping-pong banks; a bank closes on tlast, at
// MAX_PAYLOAD bytes, or after FLUSH_TIMEOUT idle clocks. Closed banks are
// drained in FIFO order through the UDP core request/stream/result handshake.
// Ports:
//   clk, reset                          - clock, synchronous active-high reset
//   s_axis_tdata/tvalid/tlast/tready    - payload input
//   stream_linked                       - destination valid; low discards input
//   dst_ip_addr, dst_port               - destination, latched at bank close
//   udp_out_start, udp_out_result       - transmit request / core status
//   udp_out_data/valid/last/ready       - payload output
//   udp_out_length/dst_ip_addr/dst_port - header of the draining bank
//   pkt_sent_count, pkt_err_count, drop_count - wrapping statistics
module udp_stream_packetizer
  import udp_stream_pkg::*;
#(
  parameter int unsigned LEN_BITS      = 10,
  parameter int unsigned MAX_PAYLOAD   = 1000,
  parameter int unsigned FLUSH_TIMEOUT = 10000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          s_axis_tdata,
  input  logic                s_axis_tvalid,
  input  logic                s_axis_tlast,
  output logic                s_axis_tready,
  input  logic                stream_linked,
  input  logic [31:0]         dst_ip_addr,
  input  logic [15:0]         dst_port,
  output logic                udp_out_start,
  input  logic [1:0]          udp_out_result,
  output logic [7:0]          udp_out_data,
  output logic                udp_out_valid,
  output logic                udp_out_last,
  input  logic                udp_out_ready,
  output logic [LEN_BITS-1:0] udp_out_length,
  output logic [31:0]         udp_out_dst_ip_addr,
  output logic [15:0]         udp_out_dst_port,
  output logic [15:0]         pkt_sent_count,
  output logic [15:0]         pkt_err_count,
  output logic [15:0]         drop_count
);

  localparam int unsigned ADDR_BITS = LEN_BITS + 1;
  localparam int unsigned IDLE_BITS = $clog2(FLUSH_TIMEOUT + 1);

  // Per-bank bookkeeping
  bank_state_t         bank_state [2];
  logic [LEN_BITS-1:0] bank_len   [2];
  logic [31:0]         bank_ip    [2];
  logic [15:0]         bank_port  [2];

  // Fill side
  logic                 open_valid;
  logic                 open_bank;
  logic [LEN_BITS-1:0]  wr_ptr;
  logic [IDLE_BITS-1:0] idle_cnt;
  logic                 accept;
  logic                 wr_en;
  logic                 at_max;
  logic                 close_byte;
  logic                 close_tmo;
  logic                 close_en;
  logic [LEN_BITS-1:0]  close_len;
  logic                 other_bank;
  logic                 other_free;
  logic                 beat_drop;

  // Drain side
  drain_state_t        dr_state;
  drain_state_t        dr_next;
  logic                rd_bank;
  logic [LEN_BITS-1:0] rd_ptr;
  logic                rd_en;
  logic                ram_vld;
  logic                ram_last;
  logic                load_out;
  logic [7:0]          rd_data;
  logic                free_en;
  logic                sent_inc;
  logic                err_inc;
  logic                pkt_drop;

  assign s_axis_tready = open_valid;

  udp_stream_bank_ram #(
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr ({open_bank, wr_ptr}),
    .wr_data (s_axis_tdata),
    .rd_en   (rd_en),
    .rd_addr ({rd_bank, rd_ptr}),
    .rd_data (rd_data)
  );

  // Fill-side decisions: accept, write, close conditions.
  always_comb begin
    accept     = s_axis_tvalid && open_valid;
    wr_en      = accept && stream_linked;
    beat_drop  = accept && !stream_linked;
    at_max     = (wr_ptr == LEN_BITS'(MAX_PAYLOAD - 1));
    close_byte = wr_en && (s_axis_tlast || at_max);
    close_tmo  = open_valid && stream_linked && !accept && (wr_ptr != '0) &&
                 (idle_cnt == IDLE_BITS'(FLUSH_TIMEOUT));
    close_en   = close_byte || close_tmo;
    close_len  = close_byte ? (wr_ptr + LEN_BITS'(1)) : wr_ptr;
    other_bank = ~open_bank;
    // A bank freed by the drain this cycle may be opened immediately.
    other_free = (bank_state[other_bank] == BANK_EMPTY) ||
                 (free_en && (rd_bank == other_bank));
  end

  // Bank state, open-bank pointer, write pointer and idle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        bank_state[b] <= BANK_EMPTY;
        bank_len[b]   <= '0;
        bank_ip[b]    <= '0;
        bank_port[b]  <= '0;
      end
      open_valid <= 1'b1;
      open_bank  <= 1'b0;
      wr_ptr     <= '0;
      idle_cnt   <= '0;
    end else begin
      if (close_en) begin
        bank_state[open_bank] <= BANK_FULL;
        bank_len[open_bank]   <= close_len;
        bank_ip[open_bank]    <= dst_ip_addr;
        bank_port[open_bank]  <= dst_port;
      end
      if (free_en) bank_state[rd_bank] <= BANK_EMPTY;

      if (close_en) begin
        wr_ptr   <= '0;
        idle_cnt <= '0;
        if (other_free) begin
          open_bank              <= other_bank;
          bank_state[other_bank] <= BANK_FILLING;
        end else begin
          open_valid <= 1'b0;
        end
      end else if (!open_valid) begin
        if (free_en) begin
          open_valid          <= 1'b1;
          open_bank           <= rd_bank;
          bank_state[rd_bank] <= BANK_FILLING;
          wr_ptr              <= '0;
          idle_cnt            <= '0;
        end
      end else begin
        if (!stream_linked) wr_ptr <= '0;
        else if (wr_en)     wr_ptr <= wr_ptr + LEN_BITS'(1);
        if (accept) idle_cnt <= '0;
        else if (idle_cnt != IDLE_BITS'(FLUSH_TIMEOUT)) idle_cnt <= idle_cnt + IDLE_BITS'(1);
      end
    end
  end

  // Drain FSM state register.
  always_ff @(posedge clk) begin
    if (reset) dr_state <= DR_IDLE;
    else       dr_state <= dr_next;
  end

  // Drain FSM next state and per-cycle strobes.
  always_comb begin
    dr_next  = dr_state;
    free_en  = 1'b0;
    sent_inc = 1'b0;
    err_inc  = 1'b0;
    pkt_drop = 1'b0;
    case (dr_state)
      DR_IDLE: begin
        if (bank_state[rd_bank] == BANK_FULL) begin
          if (stream_linked) begin
            dr_next = DR_REQ;
          end else begin
            free_en  = 1'b1;
            pkt_drop = 1'b1;
          end
        end
      end
      DR_REQ: begin
        if (udp_out_result == UDP_RES_SENDING) dr_next = DR_SEND;
      end
      DR_SEND: begin
        if (udp_out_valid && udp_out_ready && udp_out_last) dr_next = DR_WAIT;
      end
      DR_WAIT: begin
        if (udp_out_result == UDP_RES_SENT) begin
          sent_inc = 1'b1;
          dr_next  = DR_DONE;
        end else if (udp_out_result == UDP_RES_ERR) begin
          err_inc = 1'b1;
          dr_next = DR_DONE;
        end
      end
      DR_DONE: begin
        free_en = 1'b1;
        dr_next = DR_IDLE;
      end
      default: dr_next = DR_IDLE;
    endcase
  end

  // Read pipeline: RAM output stage feeds the output register; a read is
  // issued whenever the RAM stage is free or being emptied this cycle.
  always_comb begin
    load_out = ram_vld && (!udp_out_valid || udp_out_ready);
    rd_en    = ((dr_state == DR_SEND) ||
                ((dr_state == DR_REQ) && (udp_out_result == UDP_RES_SENDING))) &&
               (rd_ptr != udp_out_length) && (!ram_vld || load_out);
  end

  // Drain datapath, header fields and statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_bank             <= 1'b0;
      rd_ptr              <= '0;
      ram_vld             <= 1'b0;
      ram_last            <= 1'b0;
      udp_out_start       <= 1'b0;
      udp_out_data        <= '0;
      udp_out_valid       <= 1'b0;
      udp_out_last        <= 1'b0;
      udp_out_length      <= '0;
      udp_out_dst_ip_addr <= '0;
      udp_out_dst_port    <= '0;
      pkt_sent_count      <= '0;
      pkt_err_count       <= '0;
      drop_count          <= '0;
    end else begin
      udp_out_start <= (dr_next == DR_REQ);
      if (free_en) rd_bank <= ~rd_bank;

      // Header is captured once on REQ entry and held until the next packet.
      if ((dr_state == DR_IDLE) && (dr_next == DR_REQ)) begin
        udp_out_length      <= bank_len[rd_bank];
        udp_out_dst_ip_addr <= bank_ip[rd_bank];
        udp_out_dst_port    <= bank_port[rd_bank];
      end

      if (dr_state == DR_IDLE) rd_ptr <= '0;
      else if (rd_en)          rd_ptr <= rd_ptr + LEN_BITS'(1);

      if (rd_en) begin
        ram_vld  <= 1'b1;
        ram_last <= (rd_ptr == (udp_out_length - LEN_BITS'(1)));
      end else if (load_out) begin
        ram_vld <= 1'b0;
      end

      if (load_out) begin
        udp_out_valid <= 1'b1;
        udp_out_data  <= rd_data;
        udp_out_last  <= ram_last;
      end else if (udp_out_valid && udp_out_ready) begin
        udp_out_valid <= 1'b0;
        udp_out_last  <= 1'b0;
      end

      if (sent_inc) pkt_sent_count <= pkt_sent_count + 16'(1);
      if (err_inc)  pkt_err_count  <= pkt_err_count + 16'(1);
      drop_count <= drop_count + 16'(beat_drop) + 16'(pkt_drop);
    end
  end

endmodule
